disp_share_arb: RTL and testbench

- Shares the 4-digit multiplexed seven-segment display between two requesters (client 0 and client 1) using a req/gnt handshake.
- Fair arbitration with a minimum dwell time per owner.
- Grant changes only on frame boundaries, so a frame is never torn between clients.
- Integrates digit-scan sequencing with a per-digit blanking interval (anti-ghosting). Sits between the application sources and the board's an/sseg pins.

---
 rtl/disp_pkg.sv | 22 ++
 rtl/disp_scan_timer.sv | 56 +++++
 rtl/disp_share_arb.sv | 152 +++++++++++++++
 tb/tb_disp_share_arb.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : disp_pkg
// Purpose  : Shared types and constants for the shared seven-segment display
//            arbiter: owner-state encoding and the all-off drive patterns.
// Revision : 1.0 - initial release
// ============================================================================
package disp_pkg;

    // Owner of the display for the current frame.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_e;

    // Both anodes and segments are active-low, so "off" is all ones.
    localparam logic [3:0] AN_OFF  = 4'b1111;
    localparam logic [7:0] SEG_OFF = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/disp_scan_timer.sv
`default_nettype none
// ============================================================================
// Module   : disp_scan_timer
// Purpose  : Digit-scan sequencer. A slot counter runs 0..DIG_CYC-1 per digit
//            and the digit index steps 0..3 on every slot wrap.
// Ports    : clk          - system clock
//            reset        - asynchronous active-low reset
//            digit_nxt_o  - digit index that will be current after this edge
//            blank_nxt_o  - slot position after this edge is in the blanking
//                           interval
//            frame_end_o  - current cycle is the last cycle of a frame
// Revision : 1.0 - initial release
// ============================================================================
module disp_scan_timer #(
    parameter int DIG_CYC   = 65536,
    parameter int BLANK_CYC = 256,
    parameter int CNT_W     = 16
) (
    input  logic       clk,
    input  logic       reset,
    output logic [1:0] digit_nxt_o,
    output logic       blank_nxt_o,
    output logic       frame_end_o
);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIG_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       digit_q, digit_d;
    logic             wrap;

    always_comb begin
        wrap    = (cnt_q == CNT_LAST);
        cnt_d   = wrap ? '0 : cnt_q + 1'b1;
        digit_d = wrap ? digit_q + 2'd1 : digit_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            digit_q <= 2'd0;
        end else begin
            cnt_q   <= cnt_d;
            digit_q <= digit_d;
        end
    end

    // Next-state views let the owner register the pin drive on the same edge
    // as the counters, so the pins line up exactly with digit/cnt.
    assign digit_nxt_o = digit_d;
    assign blank_nxt_o = (cnt_d < CNT_BLANK);
    assign frame_end_o = wrap && (digit_q == 2'd3);

endmodule
`default_nettype wire

// File: rtl/disp_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : disp_share_arb
// Purpose  : Shares a 4-digit multiplexed seven-segment display between two
//            clients. Ownership changes only on frame boundaries, a minimum
//            dwell protects the current owner from preemption, and ties go to
//            the client that was not granted most recently.
// Ports    : clk        - system clock
//            reset      - asynchronous active-low reset
//            req[1:0]   - per-client level request
//            c0_data    - client 0 segments, byte k = digit k, active-low
//            c1_data    - client 1 segments, same format
//            gnt[1:0]   - one-hot-or-zero ownership indication
//            an[3:0]    - active-low digit enables
//            sseg[7:0]  - active-low segment drive (dp, a..g)
//            frame_tick - one-cycle pulse on the first cycle of each frame
// Revision : 1.0 - initial release
// ============================================================================
module disp_share_arb
    import disp_pkg::*;
#(
    parameter int DIG_CYC   = 65536,
    parameter int BLANK_CYC = 256,
    parameter int DWELL_CYC = 50_000_000,
    parameter int CNT_W     = 16,
    parameter int DWELL_W   = 26
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [31:0] c0_data,
    input  logic [31:0] c1_data,
    output logic [1:0]  gnt,
    output logic [3:0]  an,
    output logic [7:0]  sseg,
    output logic        frame_tick
);

    localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(DWELL_CYC);

    logic [1:0]         digit_nxt;
    logic               blank_nxt;
    logic               frame_end;

    state_e             state_q, state_d;
    logic               last_q, last_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [31:0]        snap_q, snap_d;
    logic [1:0]         gnt_q, gnt_d;
    logic [3:0]         an_q, an_d;
    logic [7:0]         sseg_q, sseg_d;
    logic               tick_q;
    logic               dwell_met;

    disp_scan_timer #(
        .DIG_CYC   (DIG_CYC),
        .BLANK_CYC (BLANK_CYC),
        .CNT_W     (CNT_W)
    ) u_timer (
        .clk         (clk),
        .reset       (reset),
        .digit_nxt_o (digit_nxt),
        .blank_nxt_o (blank_nxt),
        .frame_end_o (frame_end)
    );

    // Arbiter: decisions are only taken on the last cycle of a frame.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        dwell_met = (dwell_q >= DWELL_MAX);
        if (frame_end) begin
            case (state_q)
                IDLE: begin
                    if (req == 2'b11)  state_d = last_q ? OWN0 : OWN1;
                    else if (req[0])   state_d = OWN0;
                    else if (req[1])   state_d = OWN1;
                end
                OWN0: begin
                    if (!req[0])                   state_d = req[1] ? OWN1 : IDLE;
                    else if (req[1] && dwell_met)  state_d = OWN1;
                end
                OWN1: begin
                    if (!req[1])                   state_d = req[0] ? OWN0 : IDLE;
                    else if (req[0] && dwell_met)  state_d = OWN0;
                end
                default: state_d = IDLE;
            endcase
        end
        if (state_d == OWN0)      last_d = 1'b0;
        else if (state_d == OWN1) last_d = 1'b1;
    end

    // Dwell restarts on every hand-over and saturates so it never wraps.
    always_comb begin
        dwell_d = dwell_q;
        if ((state_d != state_q) || (state_d == IDLE)) dwell_d = '0;
        else if (dwell_q < DWELL_MAX)                  dwell_d = dwell_q + 1'b1;
    end

    // Snapshot the incoming owner's data so a frame is never torn.
    always_comb begin
        snap_d = snap_q;
        if (frame_end) begin
            case (state_d)
                OWN0:    snap_d = c0_data;
                OWN1:    snap_d = c1_data;
                default: snap_d = {4{SEG_OFF}};
            endcase
        end
    end

    // Pin drive computed from next-state values, registered alongside them.
    always_comb begin
        gnt_d  = {state_d == OWN1, state_d == OWN0};
        an_d   = AN_OFF;
        sseg_d = SEG_OFF;
        if ((state_d != IDLE) && !blank_nxt) begin
            an_d   = ~(4'b0001 << digit_nxt);
            sseg_d = snap_d[8*digit_nxt +: 8];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            dwell_q <= '0;
            snap_q  <= {4{SEG_OFF}};
            gnt_q   <= 2'b00;
            an_q    <= AN_OFF;
            sseg_q  <= SEG_OFF;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            dwell_q <= dwell_d;
            snap_q  <= snap_d;
            gnt_q   <= gnt_d;
            an_q    <= an_d;
            sseg_q  <= sseg_d;
            tick_q  <= frame_end;
        end
    end

    assign gnt        = gnt_q;
    assign an         = an_q;
    assign sseg       = sseg_q;
    assign frame_tick = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_disp_share_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_disp_share_arb
// Purpose  : Self-checking bench for disp_share_arb with a scoreboard queue
//            fed by a frame-position reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_disp_share_arb;

    localparam int DIG   = 8;
    localparam int BLANK = 2;
    localparam int DWELL = 40;
    localparam int FRAME = 4 * DIG;

    typedef struct packed {
        logic [1:0] gnt;
        logic [3:0] an;
        logic [7:0] sseg;
        logic       tick;
    } exp_t;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  req   = 2'b00;
    logic [31:0] c0_data = 32'hC0F9A4B0;
    logic [31:0] c1_data = 32'h92998682;
    logic [1:0]  gnt;
    logic [3:0]  an;
    logic [7:0]  sseg;
    logic        frame_tick;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   done     = 1'b0;

    always #5 clk = ~clk;

    disp_share_arb #(
        .DIG_CYC   (DIG),
        .BLANK_CYC (BLANK),
        .DWELL_CYC (DWELL),
        .CNT_W     (3),
        .DWELL_W   (6)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .c0_data    (c0_data),
        .c1_data    (c1_data),
        .gnt        (gnt),
        .an         (an),
        .sseg       (sseg),
        .frame_tick (frame_tick)
    );

    // Reference model: position within the frame, current owner (-1 = none),
    // last granted client, cycles held since the grant, frame snapshot.
    int          m_pos, m_owner, m_last, m_since, m_nxt, m_dw, m_slot, m_dig;
    bit          m_fe;
    logic [31:0] m_snap;
    exp_t        m_e;

    initial begin
        m_pos = 0; m_owner = -1; m_last = 1; m_since = 0; m_snap = '1;
        forever begin
            @(posedge clk);
            if (!reset) begin
                m_pos = 0; m_owner = -1; m_last = 1; m_since = 0; m_snap = '1;
                m_e = '{gnt: 2'b00, an: 4'hF, sseg: 8'hFF, tick: 1'b0};
            end else begin
                m_fe  = (m_pos == FRAME - 1);
                m_nxt = m_owner;
                if (m_fe) begin
                    m_dw = (m_since > DWELL) ? DWELL : m_since;
                    if (m_owner < 0) begin
                        if (req == 2'b11)  m_nxt = 1 - m_last;
                        else if (req[0])   m_nxt = 0;
                        else if (req[1])   m_nxt = 1;
                    end else if (!req[m_owner]) begin
                        m_nxt = req[1 - m_owner] ? 1 - m_owner : -1;
                    end else if (req[1 - m_owner] && m_dw >= DWELL) begin
                        m_nxt = 1 - m_owner;
                    end
                end
                if (m_nxt != m_owner)  m_since = 0;
                else if (m_owner >= 0) m_since++;
                if (m_nxt >= 0) m_last = m_nxt;
                m_owner = m_nxt;
                if (m_fe)
                    m_snap = (m_owner == 0) ? c0_data : (m_owner == 1) ? c1_data : 32'hFFFF_FFFF;
                m_pos  = (m_pos + 1) % FRAME;
                m_slot = m_pos % DIG;
                m_dig  = m_pos / DIG;
                m_e.gnt  = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
                m_e.tick = m_fe;
                if (m_owner < 0 || m_slot < BLANK) begin
                    m_e.an   = 4'hF;
                    m_e.sseg = 8'hFF;
                end else begin
                    m_e.an   = ~(4'b0001 << m_dig);
                    m_e.sseg = m_snap[8*m_dig +: 8];
                end
            end
            exp_q.push_back(m_e);
        end
    end

    // Monitor: every cycle the DUT presents a new output word; compare it.
    exp_t got, want;
    initial begin
        while (!done) begin
            @(posedge clk);
            #1;
            if (!done) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL scoreboard_empty t=%0t", $time);
                end else begin
                    want = exp_q.pop_front();
                    got  = {gnt, an, sseg, frame_tick};
                    if (got !== want) begin
                        failures++;
                        $display("FAIL outputs t=%0t got gnt=%b an=%b sseg=%h tick=%b want gnt=%b an=%b sseg=%h tick=%b",
                                 $time, got.gnt, got.an, got.sseg, got.tick,
                                 want.gnt, want.an, want.sseg, want.tick);
                    end
                end
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Mid-cycle reset pulse; outputs must clear without waiting for a clock.
    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({gnt, an, sseg, frame_tick} !== {2'b00, 4'hF, 8'hFF, 1'b0}) begin
            failures++;
            $display("FAIL async_reset got gnt=%b an=%b sseg=%h tick=%b want 00/1111/ff/0",
                     gnt, an, sseg, frame_tick);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    int wait_cnt;
    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b1;
        // Idle display with only frame ticks.
        repeat (3 * FRAME) @(negedge clk);
        // Single requester.
        req = 2'b01;
        repeat (3 * FRAME) @(negedge clk);
        // Back to idle, then both at once: tie then dwell-based alternation.
        req = 2'b00;
        repeat (2 * FRAME) @(negedge clk);
        req = 2'b11;
        repeat (10 * FRAME) @(negedge clk);
        // Mid-frame data change on the current owner.
        c0_data = 32'h8080_8080;
        c1_data = 32'h7F7F_7F7F;
        repeat (3 * FRAME) @(negedge clk);
        // Reset while client 1 owns the display.
        req = 2'b10;
        wait_cnt = 0;
        while (gnt != 2'b10 && wait_cnt < 8 * FRAME) begin
            @(negedge clk);
            wait_cnt++;
        end
        checks++;
        if (gnt != 2'b10) begin
            failures++;
            $display("FAIL gnt1_timeout got gnt=%b want 10", gnt);
        end
        repeat (DIG + 3) @(negedge clk);
        pulse_reset();
        repeat (3 * FRAME) @(negedge clk);
        // Randomized requests, data and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) req = 2'($urandom);
            if ($urandom_range(0, 15) == 0) c0_data = $urandom;
            if ($urandom_range(0, 15) == 0) c1_data = $urandom;
            if ($urandom_range(0, 799) == 0) pulse_reset();
        end
        @(negedge clk);
        done = 1'b1;
    end

endmodule
`default_nettype wire
